// File: rtl/uart_rx_fifo.sv
// Oversampling 8N1 UART receiver feeding a first-word-fall-through byte FIFO
// drained over a valid/ready handshake.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_WAIT_HI = 3'd4
    } state_t;

    state_t             state_r, state_nxt_s;
    logic               rx_meta_r, rx_sync_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2:0]         idx_r;
    logic [7:0]         shift_r;
    logic               half_hit_s, full_hit_s;
    logic               cnt_clr_s, idx_clr_s, bit_en_s, push_s, ferr_s;

    logic [7:0]         mem_r [FIFO_DEPTH];
    logic [AW:0]        wr_ptr_r, rd_ptr_r, wr_nxt_s, rd_nxt_s;
    logic               empty_r, full_r, pop_s, wr_en_s;
    logic               frame_err_r, overrun_r;

    assign half_hit_s = (cnt_r == HALF_M1);
    assign full_hit_s = (cnt_r == FULL_M1);

    // Two-flop synchronizer for the asynchronous rx pin, idling high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receiver state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Receiver next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!rx_sync_r) state_nxt_s = S_START;
                else            state_nxt_s = S_IDLE;
            end
            S_START: begin
                if (half_hit_s) state_nxt_s = rx_sync_r ? S_IDLE : S_DATA;
                else            state_nxt_s = S_START;
            end
            S_DATA: begin
                if (full_hit_s && (idx_r == 3'd7)) state_nxt_s = S_STOP;
                else                               state_nxt_s = S_DATA;
            end
            S_STOP: begin
                if (full_hit_s) state_nxt_s = rx_sync_r ? S_IDLE : S_WAIT_HI;
                else            state_nxt_s = S_STOP;
            end
            // A held-low line (break) parks here instead of decoding 0x00 frames
            S_WAIT_HI: begin
                if (rx_sync_r) state_nxt_s = S_IDLE;
                else           state_nxt_s = S_WAIT_HI;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Receiver control outputs: counter clear, bit capture, push and error strobes
    always_comb begin
        cnt_clr_s = 1'b0;
        idx_clr_s = 1'b0;
        bit_en_s  = 1'b0;
        push_s    = 1'b0;
        ferr_s    = 1'b0;
        case (state_r)
            S_IDLE: cnt_clr_s = 1'b1;
            S_START: begin
                if (half_hit_s) begin
                    cnt_clr_s = 1'b1;
                    idx_clr_s = 1'b1;
                end else begin
                    cnt_clr_s = 1'b0;
                end
            end
            S_DATA: begin
                if (full_hit_s) begin
                    cnt_clr_s = 1'b1;
                    bit_en_s  = 1'b1;
                end else begin
                    cnt_clr_s = 1'b0;
                end
            end
            S_STOP: begin
                if (full_hit_s) begin
                    cnt_clr_s = 1'b1;
                    push_s    = rx_sync_r;
                    ferr_s    = ~rx_sync_r;
                end else begin
                    cnt_clr_s = 1'b0;
                end
            end
            S_WAIT_HI: cnt_clr_s = 1'b1;
            default:   cnt_clr_s = 1'b1;
        endcase
    end

    // Bit timer, bit index and LSB-first shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
        end else begin
            cnt_r <= cnt_clr_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
            if (idx_clr_s) begin
                idx_r <= 3'd0;
            end else if (bit_en_s) begin
                idx_r <= idx_r + 3'd1;
            end else begin
                idx_r <= idx_r;
            end
            if (bit_en_s) begin
                shift_r[idx_r] <= rx_sync_r;
            end else begin
                shift_r <= shift_r;
            end
        end
    end

    // A full FIFO still accepts a push when the consumer pops in the same cycle
    assign pop_s    = ~empty_r & out_ready;
    assign wr_en_s  = push_s & (~full_r | pop_s);
    assign wr_nxt_s = wr_ptr_r + {{AW{1'b0}}, wr_en_s};
    assign rd_nxt_s = rd_ptr_r + {{AW{1'b0}}, pop_s};

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
        end
    end

    // FIFO pointers, occupancy flags and the one-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {(AW+1){1'b0}};
            rd_ptr_r    <= {(AW+1){1'b0}};
            empty_r     <= 1'b1;
            full_r      <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_nxt_s;
            rd_ptr_r    <= rd_nxt_s;
            empty_r     <= (wr_nxt_s == rd_nxt_s);
            full_r      <= (wr_nxt_s[AW] != rd_nxt_s[AW]) &&
                           (wr_nxt_s[AW-1:0] == rd_nxt_s[AW-1:0]);
            frame_err_r <= ferr_s;
            overrun_r   <= push_s & full_r & ~pop_s;
        end
    end

    assign data_out   = mem_r[rd_ptr_r[AW-1:0]];
    assign out_valid  = ~empty_r;
    assign fifo_empty = empty_r;
    assign fifo_full  = full_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Buffered UART receive path: the counterpart of the FIFO-fed transmit path (`fifo_tx` → `uart_tx`). It oversamples the serial `rx` line, decodes 8N1 frames LSB-first, and writes each good byte into an internal FWFT FIFO. The FIFO drains over a valid/ready handshake. It sits between the board `rx` pin, or the `tx` line in loopback, and the byte consumer, for example the LED controller.

## Interface
- `CLKS_PER_BIT`, 868, clocks per bit (100 MHz / 115200); ≥ 8, even
- `FIFO_DEPTH`, 16, byte entries; power of 2, ≥ 2
- `clk`  in  1  single system clock, rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `rx`  in  1  asynchronous serial input, idle high
- `data_out`  out  8  head-of-FIFO byte, valid when `out_valid`=1
- `out_valid`  out  1  FIFO not empty
- `out_ready`  in  1  consumer accepts `data_out` this cycle
- `fifo_full`  out  1  FIFO holds FIFO_DEPTH bytes
- `fifo_empty`  out  1  FIFO holds 0 bytes
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0
- `overrun`  out  1  one-cycle pulse: good byte dropped because FIFO full

## Operation
- **Input sync:** `rx` passes through a 2-flop synchronizer (`rx_s`). Both flops reset to 1.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HI. Bit counter `cnt` is ⌈log2(CLKS_PER_BIT)⌉ bits. Bit index `idx` is 3 bits.
- **IDLE:** when `rx_s`=0, go to START with `cnt`=0.
- **START:** count to CLKS_PER_BIT/2−1, then sample `rx_s`.
  - If 0: go to DATA with `cnt`=0 and `idx`=0.
  - If 1 (glitch): go to IDLE. Nothing is written and no error is flagged.
- **DATA:** at `cnt`=CLKS_PER_BIT−1, sample `rx_s` into shift bit `idx` (LSB first) and reset `cnt`. After `idx`=7, go to STOP.
- **STOP:** at `cnt`=CLKS_PER_BIT−1, sample `rx_s`.
  - If 1: push the byte and go to IDLE.
  - If 0: pulse `frame_err`, discard the byte, and go to WAIT_HI.
- **WAIT_HI:** stay until `rx_s`=1, then go to IDLE. This prevents a break condition from being decoded as repeated 0x00 frames.
- **FIFO storage:** register array with rd/wr pointers of log2(FIFO_DEPTH)+1 bits. The MSB distinguishes full from empty, and pointers wrap naturally.
- **FIFO outputs:** `data_out` = mem[rd_ptr] (first-word fall-through). `out_valid` = ~`fifo_empty`.
- **Pop:** occurs when `out_valid` && `out_ready`. `out_ready` while empty is ignored.
- **Push when full:**
  - No pop in the same cycle: byte dropped, `overrun` pulses, contents unchanged.
  - Pop in the same cycle: push accepted, occupancy stays at FIFO_DEPTH.
- **Push and pop together when not full:** both occur, occupancy unchanged.
- **Reset:** asserting `rst_n`=0 at any time, including mid-frame, immediately forces FSM=IDLE, pointers=0, and the shift register to 0.

## Timing
- **Reset values:** `data_out`=mem[0] (contents undefined, don't-care while empty), `out_valid`=0, `fifo_empty`=1, `fifo_full`=0, `frame_err`=0, `overrun`=0. Synchronizer flops=1.
- **Edge reference:** edge 0 is the clk edge that first captures `rx`=0 into sync flop 1. START is entered at edge 2.
- **Sample edges (N=CLKS_PER_BIT):**
  - Start bit: edge 2+N/2.
  - Data bit k (k=0..7): edge 2+N/2+(k+1)N.
  - Stop bit: edge 2+N/2+9N.
- **Push timing:** the write occurs on the stop-sample edge. `out_valid` and `data_out` are valid from that edge. `frame_err` and `overrun` are high for exactly the cycle following that edge.
- **Back-to-back frames:** a next start bit beginning right after the stop bit's nominal end is caught, because IDLE is re-entered N/2 clocks before the bit boundary.
- **Pop timing:** on a pop edge, `data_out` advances to the next entry in the same edge. `out_valid` drops on that edge if the FIFO becomes empty.
- **Throughput:** one byte per consumer cycle.

## Test plan
- **Reset:** hold `rst_n`=0 for 5 cycles with `rx`=1. Required: `out_valid`=0, `fifo_empty`=1, `fifo_full`=0, `frame_err`=0, `overrun`=0. Remain so for 100 idle cycles.
- **Single byte:** N=16, drive 0xA5 8N1 with `out_ready`=0. Required: `out_valid` rises at edge 2+8+144 (±1) with `data_out`=0xA5. Then `out_ready`=1 for one cycle, after which `fifo_empty`=1.
- **Glitch rejection:** `rx`=0 for 4 cycles, then 1 (N=16). Required: FSM returns to IDLE, no push, `frame_err` never asserts. A following 0x3C frame is received correctly.
- **Framing error:** send 0x3C with stop bit 0, then hold `rx`=0 for 3N cycles. Required: one `frame_err` pulse, FIFO stays empty, no further frames decoded. `rx`=1 followed by 0x55 yields `data_out`=0x55.
- **Overrun:** FIFO_DEPTH=4, `out_ready`=0, send 0x01..0x05 back-to-back. Required: `fifo_full`=1 after 0x04, one `overrun` pulse at the 0x05 stop sample. Draining returns 0x01, 0x02, 0x03, 0x04, then `fifo_empty`=1.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 4 of 0xFF, release while `rx`=1. Required: no byte pushed. A subsequent 0x81 is received exactly.
